// File: rtl/xmpl_fft_r2_core.sv
// xmpl_fft_r2_core: N-point radix-2 decimation-in-time complex FFT.
// A single butterfly iterates over a register-array frame buffer in place.
// Samples are written in bit-reversed order and bins are read out in natural order.
// Each stage halves its outputs, so a frame of X[k] comes out as X[k]/N.
// Optional feature macro: XMPL_FFT_INVERSE_EN adds inv_i (inverse transform, same 1/N scaling).
// Handshake: a beat transfers on a rising clk edge where valid and ready are both high.
//   in_ready_o is high only in LOAD and out_valid_o only in UNLOAD.
//   Both depend on the state alone, so neither combinationally depends on the partner's valid/ready.
module xmpl_fft_r2_core #(
  parameter int N_LOG2 = 4,
  parameter int DATA_W = 12,
  parameter int TW_W   = 12
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
`ifdef XMPL_FFT_INVERSE_EN
  input  logic              inv_i,
`endif
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_re_i,
  input  logic [DATA_W-1:0] in_im_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_re_o,
  output logic [DATA_W-1:0] out_im_o,
  output logic              out_last_o,
  output logic [31:0]       status_o
);
  localparam int  N  = 1 << N_LOG2;
  localparam int  HN = N / 2;
  localparam int  CW = N_LOG2;
  localparam int  BW = N_LOG2 - 1;
  localparam int  PW = DATA_W + TW_W;
  localparam int  TK = DATA_W + 1;
  localparam int  SW = DATA_W + 2;
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [SW-1:0] MAX_S = SW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_S = ~MAX_S;

  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_COMPUTE = 2'd1, ST_UNLOAD = 2'd2} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    stage;
  logic [BW-1:0] bidx;
  logic [7:0]    frames;
  logic          sat_q;
  logic          last_bfly;

  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];
  logic signed [TW_W-1:0]   tw_re [HN];
  logic signed [TW_W-1:0]   tw_im [HN];

  // Round to nearest; +1.0 does not fit Q1.(TW_W-1) so it clips to the largest code.
  function automatic logic signed [TW_W-1:0] tw_quant(input real v);
    real s;
    int  r;
    s = v * (2.0 ** (TW_W - 1));
    r = (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
    if (r > (1 << (TW_W - 1)) - 1) r = (1 << (TW_W - 1)) - 1;
    if (r < -(1 << (TW_W - 1))) r = -(1 << (TW_W - 1));
    return TW_W'(r);
  endfunction

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < CW; i++) r[i] = v[CW-1-i];
    return r;
  endfunction

  function automatic logic over(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] h;
    h = v >>> 1;
    return (h > MAX_S) || (h < MIN_S);
  endfunction

  function automatic logic signed [DATA_W-1:0] clip(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] h;
    h = v >>> 1;
    if (h > MAX_S)      h = MAX_S;
    else if (h < MIN_S) h = MIN_S;
    return DATA_W'(h);
  endfunction

  // Twiddle ROM W_k = exp(-j*2*pi*k/N), evaluated at elaboration.
  for (genvar k = 0; k < HN; k++) begin : g_tw
    localparam real ANG = 2.0 * PI * k / N;
    localparam logic signed [TW_W-1:0] WR = tw_quant($cos(ANG));
    localparam logic signed [TW_W-1:0] WI = tw_quant(-$sin(ANG));
    assign tw_re[k] = WR;
    assign tw_im[k] = WI;
  end

`ifdef XMPL_FFT_INVERSE_EN
  // Inverse twiddle imag is a separate clipped ROM, because negating -1.0 would overflow.
  logic signed [TW_W-1:0] tw_ii [HN];
  logic inv_q;
  for (genvar k = 0; k < HN; k++) begin : g_twi
    localparam logic signed [TW_W-1:0] WII = tw_quant($sin(2.0 * PI * k / N));
    assign tw_ii[k] = WII;
  end
  // Latch the direction with the first sample of each frame.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) inv_q <= 1'b0;
    else if (state == ST_LOAD && in_valid_i && cnt == '0) inv_q <= inv_i;
  end
`endif

  logic [BW-1:0] pos, k_tw;
  logic [CW-1:0] ia, ib;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im, na_re, na_im, nb_re, nb_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]       t_re_full, t_im_full;
  logic signed [TK-1:0]     t_re, t_im;
  logic signed [SW-1:0]     s_a_re, s_a_im, s_b_re, s_b_im;
  logic                     sat_now;

  // Butterfly datapath: address generation, complex multiply, scaled add/sub with saturation.
  always_comb begin
    pos  = bidx & BW'((32'd1 << stage) - 32'd1);
    ia   = CW'(((32'(bidx) >> stage) << (stage + 4'd1)) + 32'(pos));
    ib   = ia + CW'(32'd1 << stage);
    k_tw = BW'(32'(pos) << (N_LOG2 - 1 - int'(stage)));
    a_re = mem_re[ia];
    a_im = mem_im[ia];
    b_re = mem_re[ib];
    b_im = mem_im[ib];
    w_re = tw_re[k_tw];
`ifdef XMPL_FFT_INVERSE_EN
    w_im = inv_q ? tw_ii[k_tw] : tw_im[k_tw];
`else
    w_im = tw_im[k_tw];
`endif
    p_rr = b_re * w_re;
    p_ii = b_im * w_im;
    p_ri = b_re * w_im;
    p_ir = b_im * w_re;
    t_re_full = (PW+1)'(p_rr) - (PW+1)'(p_ii);
    t_im_full = (PW+1)'(p_ri) + (PW+1)'(p_ir);
    t_re   = TK'(t_re_full >>> (TW_W - 1));
    t_im   = TK'(t_im_full >>> (TW_W - 1));
    s_a_re = SW'(a_re) + SW'(t_re);
    s_a_im = SW'(a_im) + SW'(t_im);
    s_b_re = SW'(a_re) - SW'(t_re);
    s_b_im = SW'(a_im) - SW'(t_im);
    na_re  = clip(s_a_re);
    na_im  = clip(s_a_im);
    nb_re  = clip(s_b_re);
    nb_im  = clip(s_b_im);
    sat_now = over(s_a_re) | over(s_a_im) | over(s_b_re) | over(s_b_im);
  end

  assign last_bfly = (&bidx) && (stage == 4'(N_LOG2 - 1));

  // State register plus load/unload counter, butterfly counters, frame count and sticky saturation.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state  <= ST_LOAD;
      cnt    <= '0;
      stage  <= '0;
      bidx   <= '0;
      frames <= '0;
      sat_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_LOAD:    if (in_valid_i) cnt <= cnt + 1'b1;
        ST_COMPUTE: begin
          bidx  <= bidx + 1'b1;
          sat_q <= sat_q | sat_now;
          if (last_bfly)  stage <= '0;
          else if (&bidx) stage <= stage + 4'd1;
        end
        ST_UNLOAD: if (out_ready_i) begin
          cnt <= cnt + 1'b1;
          if (&cnt) frames <= frames + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Frame buffer: bit-reversed sample writes in LOAD, in-place butterfly writes in COMPUTE.
  always_ff @(posedge clk_i) begin
    if (state == ST_LOAD && in_valid_i) begin
      mem_re[bitrev(cnt)] <= in_re_i;
      mem_im[bitrev(cnt)] <= in_im_i;
    end else if (state == ST_COMPUTE) begin
      mem_re[ia] <= na_re;
      mem_im[ia] <= na_im;
      mem_re[ib] <= nb_re;
      mem_im[ib] <= nb_im;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nx    = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_re_o    = '0;
    out_im_o    = '0;
    case (state)
      ST_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && (&cnt)) state_nx = ST_COMPUTE;
      end
      ST_COMPUTE: if (last_bfly) state_nx = ST_UNLOAD;
      ST_UNLOAD: begin
        out_valid_o = 1'b1;
        out_last_o  = &cnt;
        out_re_o    = mem_re[cnt];
        out_im_o    = mem_im[cnt];
        if (out_ready_i && (&cnt)) state_nx = ST_LOAD;
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  assign status_o = {15'd0, sat_q, frames, 5'd0, state, (state != ST_LOAD)};
endmodule

// File: tb/tb_xmpl_fft_r2_core.sv
// Bench for xmpl_fft_r2_core (N=16, 12-bit data, 12-bit twiddles).
// A table of frames with hand-computed bins is pushed through the core, with the expected bins held in a queue.
// Hand-written sequences cover the mid-compute reset and the frame counter wrap.
// Optional feature macro: XMPL_FFT_INVERSE_EN adds an inverse-transform frame.
`timescale 1ns/1ps
module tb_xmpl_fft_r2_core;
  localparam int N_LOG2 = 4;
  localparam int N      = 16;
  localparam int DW     = 12;
  localparam int LAT    = N_LOG2 * N / 2 + 1;

  typedef struct packed {
    logic [N-1:0][DW-1:0] x_re;
    logic [N-1:0][DW-1:0] x_im;
    logic [N-1:0][DW-1:0] y_re;
    logic [N-1:0][DW-1:0] y_im;
    logic [7:0]           tol;
    logic                 chk;
    logic                 bp;
    logic                 sat;
    logic                 inv;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;
  logic [31:0]   status;
`ifdef XMPL_FFT_INVERSE_EN
  logic          inv = 1'b0;
`endif

  logic [2*DW-1:0] exp_q[$];
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;
  int   frames_exp = 0;
  int   sat_exp = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  xmpl_fft_r2_core #(.N_LOG2(N_LOG2), .DATA_W(DW), .TW_W(12)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
`ifdef XMPL_FFT_INVERSE_EN
    .inv_i       (inv),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_re_i     (in_re),
    .in_im_i     (in_im),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_re_o    (out_re),
    .out_im_o    (out_im),
    .out_last_o  (out_last),
    .status_o    (status)
  );

  task automatic check(input string name, input int got, input int exp, input int tol);
    int d;
    checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  // Driver: feed one frame, optionally with random idle gaps on in_valid.
  task automatic load_frame(input int v);
    int acc = 0;
    int guard = 0;
`ifdef XMPL_FFT_INVERSE_EN
    inv = vecs[v].inv;
`endif
    while (acc < N && guard < 500) begin
      @(negedge clk);
      if (vecs[v].bp && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_re = vecs[v].x_re[acc];
        in_im = vecs[v].x_im[acc];
      end
      if (in_valid && in_ready) acc++;
      guard++;
    end
    check("load_accepts", acc, N, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("ready_in_compute", int'(in_ready), 0, 0);
    check("state_compute", int'(status[2:0]), 3, 0);
  endtask

  // Receiver and scoreboard: collect the 16 bins, check latency, last flag, stall stability.
  task automatic unload_frame(input int v);
    int lat = 1;
    int idx = 0;
    int guard = 0;
    logic stall = 1'b0;
    logic [DW-1:0] hold_re = '0, hold_im = '0;
    logic [2*DW-1:0] e;
    if (vecs[v].chk)
      for (int i = 0; i < N; i++) exp_q.push_back({vecs[v].y_re[i], vecs[v].y_im[i]});
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT, 0);
    while (idx < N && guard < 200) begin
      out_ready = vecs[v].bp ? (guard % 2 == 0) : 1'b1;
      check("out_valid_in_unload", int'(out_valid), 1, 0);
      if (stall) begin
        check("stall_re_stable", int'(out_re), int'(hold_re), 0);
        check("stall_im_stable", int'(out_im), int'(hold_im), 0);
      end
      if (out_ready) begin
        check("out_last", int'(out_last), int'(idx == N - 1), 0);
        if (vecs[v].chk) begin
          e = exp_q.pop_front();
          check($sformatf("bin%0d_re", idx), int'($signed(out_re)), int'($signed(e[2*DW-1:DW])),
                int'(vecs[v].tol));
          check($sformatf("bin%0d_im", idx), int'($signed(out_im)), int'($signed(e[DW-1:0])),
                int'(vecs[v].tol));
        end
        idx++;
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        hold_re = out_re;
        hold_im = out_im;
      end
      guard++;
      @(negedge clk);
    end
    check("bins_seen", idx, N, 0);
    out_ready = 1'b1;
    frames_exp++;
    if (vecs[v].sat) sat_exp = 1;
    check("back_to_load", int'(in_ready) + 2 * int'(out_valid), 1, 0);
    check("frames_done", int'(status[15:8]), frames_exp % 256, 0);
    check("sat_sticky", int'(status[16]), sat_exp, 0);
  endtask

  task automatic run_frame(input int v);
    load_frame(v);
    unload_frame(v);
  endtask

  initial begin
    int tone[8];
    tone = '{1024, 724, 0, -724, -1024, -724, 0, 724};
    for (int v = 0; v < 7; v++) vecs[v] = '0;
    // 0: impulse 1600 -> every bin 100
    vecs[0].x_re[0] = DW'(1600);
    for (int i = 0; i < N; i++) vecs[0].y_re[i] = DW'(100);
    vecs[0].chk = 1'b1;
    // 1: DC 160 -> bin0 160; the clipped +1.0 twiddle truncates about 1 LSB per stage
    for (int i = 0; i < N; i++) vecs[1].x_re[i] = DW'(160);
    vecs[1].y_re[0] = DW'(160);
    vecs[1].tol = 8'd4;
    vecs[1].chk = 1'b1;
    // 2: cosine at bin 2 -> bins 2 and 14 at 512; truncation bias allows a few LSB
    for (int i = 0; i < N; i++) vecs[2].x_re[i] = DW'(tone[i % 8]);
    vecs[2].y_re[2]  = DW'(512);
    vecs[2].y_re[14] = DW'(512);
    vecs[2].tol = 8'd5;
    vecs[2].chk = 1'b1;
    // 3: impulse again under input gaps and alternating out_ready
    vecs[3] = vecs[0];
    vecs[3].bp = 1'b1;
    // 4: full-scale pattern that overflows a stage-2 butterfly (bins not checked)
    vecs[4].x_re[0] = DW'(2047);  vecs[4].x_im[0] = DW'(2047);
    vecs[4].x_re[2] = DW'(2047);  vecs[4].x_im[2] = DW'(2047);
    vecs[4].x_re[8] = DW'(-2048); vecs[4].x_im[8] = DW'(-2048);
    vecs[4].x_re[10] = DW'(-2048); vecs[4].x_im[10] = DW'(-2048);
    vecs[4].x_re[4] = DW'(-2048); vecs[4].x_im[4] = DW'(2047);
    vecs[4].x_re[6] = DW'(-2048); vecs[4].x_im[6] = DW'(2047);
    vecs[4].x_re[12] = DW'(2047); vecs[4].x_im[12] = DW'(-2048);
    vecs[4].x_re[14] = DW'(2047); vecs[4].x_im[14] = DW'(-2048);
    vecs[4].sat = 1'b1;
    // 5: all-zero frame for the frame counter wrap run
    // 6: inverse of the flat spectrum 100 -> x[0] about 100, rest 0
    for (int i = 0; i < N; i++) vecs[6].x_re[i] = DW'(100);
    vecs[6].y_re[0] = DW'(100);
    vecs[6].tol = 8'd4;
    vecs[6].chk = 1'b1;
    vecs[6].inv = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_out_last", int'(out_last), 0, 0);
    check("rst_out_data", int'(out_re) + int'(out_im), 0, 0);
    check("rst_status", int'(status), 0, 0);
    reset_n = 1'b1;

    for (int v = 0; v < 5; v++) run_frame(v);

    // Reset after the 5th COMPUTE cycle abandons the frame and clears status.
    load_frame(0);
    repeat (4) @(negedge clk);
    check("compute_before_reset", int'(status[2:1]), 1, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_in_ready", int'(in_ready), 1, 0);
    check("abort_out_valid", int'(out_valid), 0, 0);
    check("abort_status", int'(status), 0, 0);
    frames_exp = 0;
    sat_exp = 0;
    repeat (40) @(negedge clk);
    check("abort_no_output", int'(out_valid), 0, 0);
    run_frame(2);

`ifdef XMPL_FFT_INVERSE_EN
    run_frame(0);
    run_frame(6);
`endif

    // Frame counter wraps 255 -> 0.
    while (frames_exp < 256) run_frame(5);
    check("frame_wrap", int'(status[15:8]), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
